// File: rtl/delay_tdc_decoder.sv
// Time-to-digital decoder: coarse cycle count plus fine thermometer codes from two tapped
// chains, reported as a single interval in tap units with timeout / ordering qualifiers.
module delay_tdc_decoder #(
  parameter int TAPS = 32,
  parameter int COARSE_W = 12,
  localparam int FINE_W = $clog2(TAPS) + 1,
  localparam int RES_W = COARSE_W + FINE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [TAPS-1:0]  start_taps,
  input  logic [TAPS-1:0]  stop_taps,
  output logic             busy,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             timeout,
  output logic             order_err,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Last RUNNING count before saturation: one more idle cycle would reach 2**COARSE_W-1.
  localparam logic [COARSE_W-1:0] CNT_LAST = {{(COARSE_W-1){1'b1}}, 1'b0};

  state_t              state, state_next;
  logic [COARSE_W-1:0] counter;
  logic [FINE_W-1:0]   k_start;
  logic [FINE_W-1:0]   k_start_now, k_stop_now;
  logic [RES_W:0]      armed_val, run_val;
  logic                start_hit, stop_hit;

  // Length of the run of 1s from bit0; anything above the first 0 is a bubble.
  function automatic logic [FINE_W-1:0] therm_count(input logic [TAPS-1:0] taps);
    logic [FINE_W-1:0] count;
    logic              run;
    count = '0;
    run   = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      if (run && taps[i]) count = count + FINE_W'(1);
      else run = 1'b0;
    end
    return count;
  endfunction

  // Unsigned arithmetic at RES_W+1 bits; the top bit is the sign of the interval.
  function automatic logic [RES_W:0] interval(input logic [COARSE_W-1:0] cyc,
                                               input logic [FINE_W-1:0]   ks,
                                               input logic [FINE_W-1:0]   kp);
    return (RES_W+1)'(cyc) * (RES_W+1)'(TAPS) + (RES_W+1)'(ks) - (RES_W+1)'(kp);
  endfunction

  always_comb begin
    start_hit   = start_taps[0];
    stop_hit    = stop_taps[0];
    k_start_now = therm_count(start_taps);
    k_stop_now  = therm_count(stop_taps);
    armed_val   = interval('0, k_start_now, k_stop_now);
    run_val     = interval(counter + COARSE_W'(1), k_start, k_stop_now);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = ARMED;
      ARMED:   if (start_hit) state_next = stop_hit ? DONE : RUNNING;
      RUNNING: if (stop_hit || counter == CNT_LAST) state_next = DONE;
      DONE:    if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == ARMED) || (state == RUNNING);
    result_valid = (state == DONE);
    fsm_state    = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter   <= '0;
      k_start   <= '0;
      result    <= '0;
      timeout   <= 1'b0;
      order_err <= 1'b0;
    end else begin
      case (state)
        IDLE: counter <= '0;
        ARMED: begin
          if (start_hit) begin
            k_start <= k_start_now;
            counter <= '0;
            if (stop_hit) begin
              result    <= armed_val[RES_W] ? '0 : armed_val[RES_W-1:0];
              order_err <= armed_val[RES_W];
              timeout   <= 1'b0;
            end
          end
        end
        RUNNING: begin
          if (stop_hit) begin
            result    <= run_val[RES_W] ? '0 : run_val[RES_W-1:0];
            order_err <= run_val[RES_W];
            timeout   <= 1'b0;
          end else if (counter == CNT_LAST) begin
            result    <= '1;
            timeout   <= 1'b1;
            order_err <= 1'b0;
          end else begin
            counter <= counter + COARSE_W'(1);
          end
        end
        DONE: begin
          // result is deliberately left holding its value after acceptance.
          if (result_ready) begin
            timeout   <= 1'b0;
            order_err <= 1'b0;
          end
        end
        default: counter <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_tdc_decoder.sv
// Bench for delay_tdc_decoder: table of measurements, random fine codes, and hand-written
// sequences for backpressure, timeout and mid-measurement reset.
module tb_delay_tdc_decoder;
  localparam int TAPS = 32;
  localparam int COARSE_W = 12;
  localparam int RES_W = 18;
  localparam int W = RES_W + 2;

  logic             clk = 1'b0;
  logic             reset, arm, result_ready;
  logic [TAPS-1:0]  start_taps, stop_taps;
  logic             busy, result_valid, timeout, order_err;
  logic [RES_W-1:0] result;
  logic [1:0]       fsm_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [31:0]      s;
    logic [31:0]      p;
    logic [31:0]      s_run;
    logic [31:0]      pre_p;
    int               gap;
    logic [RES_W-1:0] res;
    logic             oe;
  } vec_t;

  vec_t vecs[10];

  delay_tdc_decoder #(.TAPS(TAPS), .COARSE_W(COARSE_W)) dut (
    .clk(clk), .reset(reset), .arm(arm),
    .start_taps(start_taps), .stop_taps(stop_taps),
    .busy(busy), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .timeout(timeout), .order_err(order_err),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_taps(input int k);
    logic [63:0] t;
    t = (64'd1 << k) - 64'd1;
    t = t | ({32'd0, $urandom} << (k + 1));
    return t[31:0];
  endfunction

  // Arms, optionally shows a lone stop hit first, then start and stop gap cycles apart.
  task automatic drive_meas(input vec_t v);
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
    if (v.pre_p != 0) begin
      stop_taps = v.pre_p;
      @(posedge clk); #1 stop_taps = '0;
      check("lone_stop_busy", busy, 1);
      check("lone_stop_valid", result_valid, 0);
    end
    start_taps = v.s;
    stop_taps  = (v.gap == 0) ? v.p : '0;
    exp_q.push_back({v.res, 1'b0, v.oe});
    for (int i = 1; i <= v.gap; i++) begin
      @(posedge clk); #1;
      start_taps = v.s_run;
      stop_taps  = (i == v.gap) ? v.p : '0;
    end
    @(negedge clk);
    check("pre_stop_valid", result_valid, 0);
    check("pre_stop_busy", busy, 1);
    @(posedge clk); #1;
    start_taps = '0;
    stop_taps  = '0;
  endtask

  // Waits (bounded) for result_valid, compares against the scoreboard, then accepts.
  task automatic collect(input int max_wait, input int exp_wait);
    int waited;
    logic [W-1:0] e;
    waited = 0;
    while (!result_valid && waited < max_wait) begin
      @(posedge clk); #1;
      waited++;
    end
    check("latency", waited, exp_wait);
    check("sb_nonempty", exp_q.size() != 0, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check("result", result, e[W-1:2]);
    check("timeout", timeout, e[1]);
    check("order_err", order_err, e[0]);
    check("done_busy", busy, 0);
    result_ready = 1'b1;
    @(posedge clk); #1 result_ready = 1'b0;
    check("accept_valid", result_valid, 0);
    check("accept_timeout", timeout, 0);
    check("accept_order_err", order_err, 0);
    check("accept_result_held", result, e[W-1:2]);
    check("accept_busy", busy, 0);
  endtask

  initial begin
    vecs[0] = '{32'h0000001F, 32'h000FFFFF, 32'h0, 32'h0,      3, 18'd81,  1'b0};
    vecs[1] = '{32'h000FFFFF, 32'h0000001F, 32'h0, 32'h0,      0, 18'd15,  1'b0};
    vecs[2] = '{32'h0000001F, 32'h000FFFFF, 32'h0, 32'h0,      0, 18'd0,   1'b1};
    vecs[3] = '{32'h000000F7, 32'h00000007, 32'h0, 32'h0,      2, 18'd64,  1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0,      1, 18'd63,  1'b0};
    vecs[5] = '{32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0,      1, 18'd1,   1'b0};
    vecs[6] = '{32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0,      0, 18'd0,   1'b1};
    vecs[7] = '{32'h00000003, 32'h00000005, 32'hFFFFFFFF, 32'h0, 5, 18'd161, 1'b0};
    vecs[8] = '{32'h000000FF, 32'h000000FF, 32'h0, 32'h000000FF, 0, 18'd0, 1'b0};
    vecs[9] = '{32'h0000001F, 32'h00000003, 32'h0, 32'h0000FFFF, 1, 18'd35, 1'b0};

    reset = 1'b1; arm = 1'b0; result_ready = 1'b0;
    start_taps = '0; stop_taps = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_timeout", timeout, 0);
    check("rst_order_err", order_err, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive_meas(vecs[i]);
      collect(20, 0);
    end

    for (int r = 0; r < 6; r++) begin
      int ks, kp, g, v;
      vec_t t;
      ks = $urandom_range(1, 32);
      kp = $urandom_range(1, 32);
      g  = $urandom_range(0, 6);
      t.s = mk_taps(ks); t.p = mk_taps(kp);
      t.s_run = '0; t.pre_p = '0; t.gap = g;
      v = g * TAPS + ks - kp;
      t.res = (v < 0) ? '0 : RES_W'(v);
      t.oe  = (v < 0);
      drive_meas(t);
      collect(20, 0);
    end

    // Backpressure: result must hold and arm must be ignored while DONE.
    drive_meas(vecs[0]);
    for (int i = 0; i < 10; i++) begin
      arm = i[0];
      @(posedge clk); #1;
      check("hold_valid", result_valid, 1);
      check("hold_result", result, 81);
      check("hold_busy", busy, 0);
    end
    arm = 1'b1;
    collect(20, 0);
    arm = 1'b0;
    @(posedge clk); #1;
    check("arm_ignored_on_accept", busy, 0);
    drive_meas(vecs[3]);
    collect(20, 0);

    // No stop edge: saturates after 4095 RUNNING cycles.
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0; start_taps = 32'h1F;
    exp_q.push_back({{RES_W{1'b1}}, 1'b1, 1'b0});
    @(posedge clk); #1 start_taps = '0;
    check("running_busy", busy, 1);
    collect(5000, 4095);

    // Reset mid-measurement, then a stray stop hit must not start anything.
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0; start_taps = 32'h1F;
    @(posedge clk); #1 start_taps = '0;
    @(posedge clk); #1;
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_state", fsm_state, 0);
    reset = 1'b0;
    stop_taps = 32'hFF;
    @(posedge clk); #1 stop_taps = '0;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", result_valid, 0);
      @(posedge clk); #1;
    end
    drive_meas(vecs[4]);
    collect(20, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
